// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//   Parametrised multi-port register file for the MIPS datapath. Two write
//   ports (ALU writeback on port 0, load/late writeback on port 1), NUM_RD
//   combinational read ports, optional write-through bypass, optional
//   hardwired zero register and a registered same-address write-collision flag.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width; depth = 2**ADDR_W
//   NUM_RD   number of read ports (1..4)
//   BYPASS   1: same-cycle write data is forwarded to matching read lanes
//   ZERO_REG 1: register 0 reads 0 and ignores writes
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   regWrite0/1           write enables (port 1 wins on a same-address write)
//   writeReg0/1           write addresses
//   writeData0/1          write data
//   readReg               packed read addresses, lane k = [k*ADDR_W +: ADDR_W]
//   readData              packed read data,      lane k = [k*DATA_W +: DATA_W]
//   wrCollide             1 for one cycle after an effective same-address dual write
// -----------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     regWrite0,
    input  logic [ADDR_W-1:0]        writeReg0,
    input  logic [DATA_W-1:0]        writeData0,
    input  logic                     regWrite1,
    input  logic [ADDR_W-1:0]        writeReg1,
    input  logic [DATA_W-1:0]        writeData1,
    input  logic [NUM_RD*ADDR_W-1:0] readReg,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic                     wrCollide
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_wr_collide;

    // Effective write enables: a write to the hardwired zero register is
    // dropped here, so it neither updates the array, bypasses, nor collides.
    logic w_we0;
    logic w_we1;
    logic w_same_addr;

    assign w_we0       = regWrite0 && !(ZERO_EN && (writeReg0 == '0));
    assign w_we1       = regWrite1 && !(ZERO_EN && (writeReg1 == '0));
    assign w_same_addr = (writeReg0 == writeReg1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is deliberately reset; software relies on every
            // register reading 0 after reset, so this cannot become plain RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; when both ports hit the same
            // address the later assignment (port 1) is the one that lands.
            if (w_we0) r_regs[writeReg0] <= writeData0;
            if (w_we1) r_regs[writeReg1] <= writeData1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_collide <= 1'b0;
        end else begin
            r_wr_collide <= w_we0 && w_we1 && w_same_addr;
        end
    end

    assign wrCollide = r_wr_collide;

    // Read lanes: zero-latency lookup, then forwarding (port 1 applied last so
    // it has priority), with reset and the zero register overriding everything.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_rd;

        assign w_addr = readReg[k*ADDR_W +: ADDR_W];

        always_comb begin
            // NOTE: default assigned first so no path leaves w_rd unassigned
            // and no latch is inferred.
            w_rd = '0;
            if (rst_n && !(ZERO_EN && (w_addr == '0))) begin
                w_rd = r_regs[w_addr];
                if (BYPASS_EN && w_we0 && (writeReg0 == w_addr)) w_rd = writeData0;
                if (BYPASS_EN && w_we1 && (writeReg1 == w_addr)) w_rd = writeData1;
            end
        end

        assign readData[k*DATA_W +: DATA_W] = w_rd;
    end

endmodule
